sqrt_iter: RTL and testbench



---
 rtl/sqrt_pkg.sv | 25 ++
 rtl/sqrt_step.sv | 41 ++++
 rtl/sqrt_iter.sv | 126 ++++++++++++
 tb/tb_sqrt_iter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and sizing helpers for the iterative square-root unit.
//   state_t     - controller state encoding (IDLE, CALC)
//   sqrt_h      - root width / iteration count derived from the operand width
//   sqrt_cnt_w  - width of the iteration counter for a given iteration count
// Optional feature macro used by this slice: SQRT_ROUND_EN (see sqrt_iter.sv).
package sqrt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    function automatic int sqrt_h(input int width);
        return width / 2;
    endfunction

    // Counter holds H-1 down to 0, so $clog2(H) bits are enough.
    function automatic int sqrt_cnt_w(input int h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

    localparam int SQRT_DEF_WIDTH = 8;
    localparam int SQRT_DEF_CNT_W = $clog2(SQRT_DEF_WIDTH / 2);

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational restoring square-root iteration.
// Ports:
//   root_i  [H-1:0] partial root so far
//   rem_i   [H-1:0] partial remainder so far (never exceeds H bits mid-run)
//   bits_i  [1:0]   next two operand bits, MSB first
//   root_o  [H-1:0] partial root with one more result bit appended
//   rem_o   [H:0]   new remainder (full H+1 bits for the final step)
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int H = 4
) (
    input  logic [H-1:0] root_i,
    input  logic [H-1:0] rem_i,
    input  logic [1:0]   bits_i,
    output logic [H-1:0] root_o,
    output logic [H:0]   rem_o
);

    logic [H+1:0] rem_t;
    logic [H+1:0] trial;
    logic [H+1:0] diff;
    logic         unused_diff_msb;

    assign rem_t = {rem_i, bits_i};
    assign trial = {root_i, 2'b01};
    assign diff  = rem_t - trial;

    // diff is only used when rem_t >= trial; the result then fits in H+1 bits.
    assign unused_diff_msb = diff[H+1];

    always_comb begin
        root_o = {root_i[H-2:0], 1'b0};
        rem_o  = rem_t[H:0];
        if (rem_t >= trial) begin
            root_o = {root_i[H-2:0], 1'b1};
            rem_o  = diff[H:0];
        end
    end

endmodule

// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative unsigned integer square root, one result bit per cycle.
// Computes sqrt = floor(sqrt(n)) and rem = n - sqrt^2 with fixed latency H+1.
// Parameters:
//   WIDTH - operand width, even and >= 4; H = WIDTH/2 is derived.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   go     - start request, sampled while idle
//   n      - operand, captured when go is accepted
//   busy   - computation in progress
//   over   - one-cycle completion pulse
//   sqrt   - result root (held until the next completion)
//   rem    - remainder n - floor_root^2 (held until the next completion)
// Optional build macro: SQRT_ROUND_EN - round sqrt to nearest, saturating
// at 2^H-1; rem stays the unrounded floor remainder.
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int H     = sqrt_h(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             over,
    output logic [H-1:0]     sqrt,
    output logic [H:0]       rem
);

    localparam int CNT_W = sqrt_cnt_w(H);

    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("sqrt_iter: WIDTH must be even and >= 4");
    end

    // Handshake: go is accepted on a rising edge only while idle (busy=0);
    // busy rises on that edge and stays high for H cycles; over is high for
    // exactly the following cycle with busy low, and sqrt/rem update on that
    // same edge. go while busy is dropped; go during the over cycle starts
    // the next operation immediately.

    state_t           state_q;
    logic [WIDTH-1:0] n_q;
    logic [H-1:0]     root_q;
    logic [H-1:0]     rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             over_q;
    logic [H-1:0]     sqrt_q;
    logic [H:0]       rem_out_q;

    logic [H-1:0]     step_root;
    logic [H:0]       step_rem;
    logic [H-1:0]     sqrt_d;

    sqrt_step #(.H(H)) u_step (
        .root_i (root_q),
        .rem_i  (rem_q),
        .bits_i (n_q[WIDTH-1 -: 2]),
        .root_o (step_root),
        .rem_o  (step_rem)
    );

`ifdef SQRT_ROUND_EN
    // rem > root means n is past the midpoint (root+0.5)^2, so round up.
    always_comb begin
        sqrt_d = step_root;
        if (({1'b0, step_root} < step_rem) && (step_root != '1)) begin
            sqrt_d = step_root + H'(1);
        end
    end
`else
    assign sqrt_d = step_root;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            root_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
            sqrt_q    <= '0;
            rem_out_q <= '0;
        end else begin
            over_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q <= CALC;
                        n_q     <= n;
                        root_q  <= '0;
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(H - 1);
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    n_q    <= {n_q[WIDTH-3:0], 2'b00};
                    root_q <= step_root;
                    // Partial remainders before the last step fit in H bits.
                    rem_q  <= step_rem[H-1:0];
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        over_q    <= 1'b1;
                        sqrt_q    <= sqrt_d;
                        rem_out_q <= step_rem;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign over = over_q;
    assign sqrt = sqrt_q;
    assign rem  = rem_out_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: directed bench for sqrt_iter at WIDTH=8 and WIDTH=16.
module tb_sqrt_iter;

    logic        clk = 1'b0;
    logic        reset;

    logic        go8;
    logic [7:0]  n8;
    logic        busy8;
    logic        over8;
    logic [3:0]  sqrt8;
    logic [4:0]  rem8;

    logic        go16;
    logic [15:0] n16;
    logic        busy16;
    logic        over16;
    logic [7:0]  sqrt16;
    logic [8:0]  rem16;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SQRT_ROUND_EN
    localparam logic [3:0] EXP_211 = 4'd15;
`else
    localparam logic [3:0] EXP_211 = 4'd14;
`endif

    sqrt_iter #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .go    (go8),
        .n     (n8),
        .busy  (busy8),
        .over  (over8),
        .sqrt  (sqrt8),
        .rem   (rem8)
    );

    sqrt_iter #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .go    (go16),
        .n     (n16),
        .busy  (busy16),
        .over  (over16),
        .sqrt  (sqrt16),
        .rem   (rem16)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge: present go for exactly one rising edge, then
    // scramble n so a late capture would be visible.
    task automatic go8_now(input logic [7:0] v);
        go8 = 1'b1;
        n8  = v;
        @(posedge clk);
        #1;
        go8 = 1'b0;
        n8  = 8'hA5;
    endtask

    task automatic drive_go8(input logic [7:0] v);
        @(negedge clk);
        go8_now(v);
    endtask

    task automatic drive_go16(input logic [15:0] v);
        @(negedge clk);
        go16 = 1'b1;
        n16  = v;
        @(posedge clk);
        #1;
        go16 = 1'b0;
        n16  = 16'h5AA5;
    endtask

    // Count negedges until over is seen (bounded); also count busy cycles
    // and cycles where over and busy overlap.
    task automatic wait_over8(output int cyc, output int bcnt, output int ovl);
        cyc = 0; bcnt = 0; ovl = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (busy8) bcnt++;
            if (busy8 && over8) ovl++;
            if (over8) break;
        end
    endtask

    task automatic wait_over16(output int cyc, output int bcnt);
        cyc = 0; bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cyc++;
            if (busy16) bcnt++;
            if (over16) break;
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        reset = 1'b1;
        go8 = 1'b0; n8 = '0;
        go16 = 1'b0; n16 = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy8, over8, sqrt8, rem8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b over=%b sqrt=%0d rem=%0d, want all 0", busy8, over8, sqrt8, rem8);
        end
        n_checks++;
        if ({busy16, over16, sqrt16, rem16} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_w16: got busy=%b over=%b sqrt=%0d rem=%0d, want all 0", busy16, over16, sqrt16, rem16);
        end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        int cyc, bcnt, ovl;
        drive_go8(8'd144);
        wait_over8(cyc, bcnt, ovl);
        n_checks++;
        if (cyc !== 5) begin
            n_fail++;
            $display("FAIL latency_144: over seen after %0d cycles, want 5", cyc);
        end
        n_checks++;
        if (bcnt !== 4) begin
            n_fail++;
            $display("FAIL busy_len_144: busy high %0d cycles, want 4", bcnt);
        end
        n_checks++;
        if (ovl !== 0) begin
            n_fail++;
            $display("FAIL over_busy_144: overlap %0d cycles, want 0", ovl);
        end
        n_checks++;
        if (sqrt8 !== 4'd12 || rem8 !== 5'd0) begin
            n_fail++;
            $display("FAIL result_144: got sqrt=%0d rem=%0d, want 12/0", sqrt8, rem8);
        end
        @(negedge clk);
        n_checks++;
        if (over8 !== 1'b0 || sqrt8 !== 4'd12 || rem8 !== 5'd0) begin
            n_fail++;
            $display("FAIL over_width_144: got over=%b sqrt=%0d rem=%0d, want 0/12/0", over8, sqrt8, rem8);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] vn [6];
        logic [3:0] vs [6];
        logic [4:0] vr [6];
        int cyc, bcnt, ovl;
        vn = '{8'd0, 8'd255, 8'd2, 8'd210, 8'd211, 8'd49};
        vs = '{4'd0, 4'd15,  4'd1, 4'd14,  EXP_211, 4'd7};
        vr = '{5'd0, 5'd30,  5'd1, 5'd14,  5'd15,   5'd0};
        for (int i = 0; i < 6; i++) begin
            drive_go8(vn[i]);
            wait_over8(cyc, bcnt, ovl);
            n_checks++;
            if (cyc !== 5 || sqrt8 !== vs[i] || rem8 !== vr[i]) begin
                n_fail++;
                $display("FAIL vector_n%0d: got cyc=%0d sqrt=%0d rem=%0d, want 5/%0d/%0d",
                         vn[i], cyc, sqrt8, rem8, vs[i], vr[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt, ovl;
        drive_go8(8'd100);
        @(negedge clk);
        // Previous result (49 -> 7/0) must still be showing mid-computation.
        n_checks++;
        if (sqrt8 !== 4'd7 || rem8 !== 5'd0 || busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_busy: got busy=%b sqrt=%0d rem=%0d, want 1/7/0", busy8, sqrt8, rem8);
        end
        go8_now(8'd9);
        wait_over8(cyc, bcnt, ovl);
        n_checks++;
        if (over8 !== 1'b1 || sqrt8 !== 4'd10 || rem8 !== 5'd0) begin
            n_fail++;
            $display("FAIL ignore_go: got over=%b sqrt=%0d rem=%0d, want 1/10/0", over8, sqrt8, rem8);
        end
        // Still in the over cycle: start the next operation now.
        go8_now(8'd9);
        wait_over8(cyc, bcnt, ovl);
        n_checks++;
        if (cyc !== 5 || bcnt !== 4 || ovl !== 0) begin
            n_fail++;
            $display("FAIL b2b_timing: got cyc=%0d busy=%0d overlap=%0d, want 5/4/0", cyc, bcnt, ovl);
        end
        n_checks++;
        if (sqrt8 !== 4'd3 || rem8 !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_result: got sqrt=%0d rem=%0d, want 3/0", sqrt8, rem8);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, bcnt, ovl, seen;
        drive_go8(8'd200);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy8, over8, sqrt8, rem8} !== 11'd0) begin
            n_fail++;
            $display("FAIL abort_clear: got busy=%b over=%b sqrt=%0d rem=%0d, want all 0", busy8, over8, sqrt8, rem8);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (over8 || busy8) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_over: busy/over seen %0d cycles, want 0", seen);
        end
        drive_go8(8'd49);
        wait_over8(cyc, bcnt, ovl);
        n_checks++;
        if (cyc !== 5 || sqrt8 !== 4'd7 || rem8 !== 5'd0) begin
            n_fail++;
            $display("FAIL after_abort_49: got cyc=%0d sqrt=%0d rem=%0d, want 5/7/0", cyc, sqrt8, rem8);
        end
    endtask

    task automatic test_width16();
        int cyc, bcnt;
        drive_go16(16'd65535);
        wait_over16(cyc, bcnt);
        n_checks++;
        if (cyc !== 9 || bcnt !== 8) begin
            n_fail++;
            $display("FAIL w16_timing: got cyc=%0d busy=%0d, want 9/8", cyc, bcnt);
        end
        n_checks++;
        if (sqrt16 !== 8'd255 || rem16 !== 9'd510) begin
            n_fail++;
            $display("FAIL w16_max: got sqrt=%0d rem=%0d, want 255/510", sqrt16, rem16);
        end
        drive_go16(16'd1);
        wait_over16(cyc, bcnt);
        n_checks++;
        if (cyc !== 9 || sqrt16 !== 8'd1 || rem16 !== 9'd0) begin
            n_fail++;
            $display("FAIL w16_one: got cyc=%0d sqrt=%0d rem=%0d, want 9/1/0", cyc, sqrt16, rem16);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
